// File: rtl/cpu_int_ctrl.sv
// 6502 interrupt controller: RESET/NMI/IRQ detection, arbitration and the 7-step service sequence.
// Optional NMI hijack of IRQ/BRK services is enabled by defining NMI_HIJACK_EN.
module cpu_int_ctrl #(
  parameter logic [15:0] VEC_NMI     = 16'hFFFA,
  parameter logic [15:0] VEC_RST     = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ     = 16'hFFFE,
  parameter int unsigned HIJACK_STEP = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic        poll,
  input  logic        brk,
  input  logic        int_ack,
  output logic        int_pending,
  output logic [1:0]  int_kind,
  output logic        busy,
  output logic [2:0]  step,
  output logic [15:0] vector_addr,
  output logic        push_b,
  output logic        push_en,
  output logic        set_i
);

  typedef enum logic {IDLE, SERVICE} state_t;
  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_NMI  = 2'd1,
    KIND_IRQ  = 2'd2,
    KIND_RST  = 2'd3
  } kind_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  kind_t       svc_kind_q, svc_kind_d, pend_kind;
  logic        push_b_q, push_b_d;
  logic [15:0] vec_q;
  logic        rst_latched, nmi_latched, nmi_prev, irq_latched;
  logic        nmi_set, svc_done, in_window;

  function automatic logic [15:0] kind_vec(input kind_t k);
    case (k)
      KIND_NMI: kind_vec = VEC_NMI;
      KIND_RST: kind_vec = VEC_RST;
      default:  kind_vec = VEC_IRQ;
    endcase
  endfunction

  assign nmi_set   = cpu_ce & nmi_prev & ~nmi_n;
  assign in_window = 32'(step_q) < HIJACK_STEP;

  always_comb begin
    if (rst_latched)      pend_kind = KIND_RST;
    else if (nmi_latched) pend_kind = KIND_NMI;
    else if (irq_latched) pend_kind = KIND_IRQ;
    else                  pend_kind = KIND_NONE;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    svc_kind_d = svc_kind_q;
    push_b_d   = push_b_q;
    svc_done   = 1'b0;
    case (state_q)
      IDLE: begin
        // Ack/BRK see the latches as they stand before any same-cycle poll update.
        if (cpu_ce && (brk || (int_ack && pend_kind != KIND_NONE))) begin
          state_d = SERVICE;
          step_d  = 3'd0;
          if (pend_kind == KIND_NONE) begin
            svc_kind_d = KIND_IRQ;
            push_b_d   = 1'b1;
          end else begin
            svc_kind_d = pend_kind;
            push_b_d   = 1'b0;
          end
        end
      end
      SERVICE: begin
        if (cpu_ce) begin
`ifdef NMI_HIJACK_EN
          if (svc_kind_q == KIND_IRQ && in_window && (nmi_latched || nmi_set))
            svc_kind_d = KIND_NMI;
`endif
          if (step_q == 3'd6) begin
            svc_done = 1'b1;
            state_d  = IDLE;
            step_d   = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      step_q     <= 3'd0;
      svc_kind_q <= KIND_NONE;
      push_b_q   <= 1'b0;
      vec_q      <= VEC_RST;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      svc_kind_q <= svc_kind_d;
      push_b_q   <= push_b_d;
      // The vector tracks the taken kind until the freeze step, then holds.
      if (state_q == IDLE || in_window)
        vec_q <= kind_vec(svc_kind_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_latched <= 1'b1;
      nmi_latched <= 1'b0;
      nmi_prev    <= 1'b1;
      irq_latched <= 1'b0;
    end else if (cpu_ce) begin
      nmi_prev <= nmi_n;
      // A fresh NMI edge beats the completion clear.
      if (nmi_set)
        nmi_latched <= 1'b1;
      else if (svc_done && svc_kind_q == KIND_NMI)
        nmi_latched <= 1'b0;
      if (svc_done && svc_kind_q == KIND_RST)
        rst_latched <= 1'b0;
      if (poll)
        irq_latched <= ~irq_n & ~i_flag;
      else if (svc_done && svc_kind_q == KIND_IRQ)
        irq_latched <= 1'b0;
    end
  end

  assign busy        = (state_q == SERVICE);
  assign step        = step_q;
  assign int_pending = rst_latched | nmi_latched | irq_latched;
  assign int_kind    = busy ? svc_kind_q : pend_kind;
  assign vector_addr = busy ? vec_q : kind_vec(pend_kind);
  assign push_b      = busy & push_b_q;
  assign push_en     = busy & (svc_kind_q != KIND_RST);
  assign set_i       = svc_done;

endmodule
